// File: rtl/env_pkg.sv
// Shared definitions for the envelope record/replay blocks.
//   - recorder state encoding
//   - fixed-point format of the amplitude stream and the quantiser shift
//   - slot-index helpers for the packed levels/times buses (slot LEN-1 is the
//     first level, slot LEN-2 the first duration)
`ifndef FPWIDTH
`define FPWIDTH 16
`endif
`ifndef BITS
`define BITS `FPWIDTH
`endif

package env_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRec,
    StCommit
  } env_state_e;

  localparam int unsigned FpWidth = `FPWIDTH;

  // Keep the sign bit plus `depth` magnitude bits of the fixed-point sample.
  function automatic int unsigned quant_shift(input int unsigned depth);
    return FpWidth - depth - 1;
  endfunction

  function automatic int unsigned first_level_slot(input int unsigned len);
    return len - 1;
  endfunction

  function automatic int unsigned first_time_slot(input int unsigned len);
    return len - 2;
  endfunction

endpackage

// File: rtl/env_quantize.sv
// Combinational saturating quantiser: signed fixed-point sample -> Depth-bit level.
//   sample_i : signed amplitude sample
//   level_o  : quantised level; negative samples give 0, overflow gives all ones
module env_quantize
  import env_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = `BITS
) (
  input  logic [Width-1:0] sample_i,
  output logic [Depth-1:0] level_o
);

  localparam int unsigned     Shift    = quant_shift(Depth);
  localparam logic [Width-1:0] MaxLevel = Width'((1 << Depth) - 1);

  logic [Width-1:0] shifted;

  always_comb begin
    shifted = sample_i >> Shift;
    if (sample_i[Width-1]) begin
      level_o = '0;
    end else if (shifted > MaxLevel) begin
      level_o = '1;
    end else begin
      level_o = shifted[Depth-1:0];
    end
  end

endmodule

// File: rtl/env_recorder.sv
// Envelope recorder: quantises an amplitude stream after a trigger and measures
// how long each level is held, producing levels/times buses in the layout an
// envelope sequencer replays.
//   clk, rst     : clock, asynchronous active-low reset
//   ena          : clock enable, low freezes all state
//   trigger      : start/restart recording (rising edge)
//   sampleValid  : one-cycle strobe per sample, sampleIn the signed amplitude
//   levels/times : committed envelope, updated only on commit
//   busy         : armed or recording
//   done         : one-cycle pulse when a recording is committed
module env_recorder
  import env_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LEN    = 4,
  parameter int unsigned TSCALE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     trigger,
  input  logic                     sampleValid,
  input  logic [`BITS-1:0]         sampleIn,
  output logic [DEPTH*LEN-1:0]     levels,
  output logic [DEPTH*(LEN-1)-1:0] times,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned TShift   = $clog2(TSCALE);
  localparam int unsigned SW       = DEPTH + TShift;
  localparam int unsigned PW       = (LEN > 2) ? $clog2(LEN - 1) : 1;
  localparam int unsigned LW       = $clog2(LEN);
  localparam int unsigned FirstLev = first_level_slot(LEN);

  localparam logic [PW-1:0] FirstTim = PW'(first_time_slot(LEN));
  // Longest representable duration; reaching it closes the slot so s never wraps.
  localparam logic [SW-1:0] ForceS   = SW'(((1 << DEPTH) - 1) * TSCALE);

  typedef logic [LEN-1:0][DEPTH-1:0] lev_bus_t;
  typedef logic [LEN-2:0][DEPTH-1:0] tim_bus_t;

  env_state_e       state_q, state_d;
  lev_bus_t         levels_q, levels_d, lev_w_q, lev_w_d;
  tim_bus_t         times_q, times_d, tim_w_q, tim_w_d;
  logic [DEPTH-1:0] cur_q, cur_d;
  logic [SW-1:0]    s_q, s_d;
  logic [PW-1:0]    p_q, p_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;

  logic [DEPTH-1:0] q;
  logic [SW-1:0]    u;
  logic [LW-1:0]    p_lev;
  logic             trig_rise;
  logic             force_close;
  logic             change_close;

  env_quantize #(
    .Depth(DEPTH),
    .Width(`BITS)
  ) u_quantize (
    .sample_i(sampleIn),
    .level_o (q)
  );

  assign u            = s_q >> TShift;
  assign p_lev        = LW'(p_q);
  assign trig_rise    = trigger & ~trig_q;
  assign force_close  = (s_q == ForceS);
  assign change_close = (q != cur_q) && (u != '0);

  always_comb begin
    state_d  = state_q;
    levels_d = levels_q;
    times_d  = times_q;
    lev_w_d  = lev_w_q;
    tim_w_d  = tim_w_q;
    cur_d    = cur_q;
    s_d      = s_q;
    p_d      = p_q;
    trig_d   = trig_q;
    done_d   = 1'b0;

    if (ena) begin
      trig_d = trigger;
      unique case (state_q)
        StIdle: begin
          if (trig_rise) begin
            state_d = StArmed;
            lev_w_d = '0;
            tim_w_d = '0;
            cur_d   = '0;
            s_d     = '0;
            p_d     = '0;
          end
        end
        StArmed: begin
          if (trig_rise) begin
            lev_w_d = '0;
            tim_w_d = '0;
            cur_d   = '0;
            s_d     = '0;
            p_d     = '0;
          end else if (sampleValid) begin
            lev_w_d[FirstLev] = q;
            cur_d             = q;
            s_d               = SW'(1);
            p_d               = FirstTim;
            state_d           = StRec;
          end
        end
        StRec: begin
          // A trigger edge beats a close in the same cycle, including the final one.
          if (trig_rise) begin
            state_d = StArmed;
            lev_w_d = '0;
            tim_w_d = '0;
            cur_d   = '0;
            s_d     = '0;
            p_d     = '0;
          end else if (sampleValid) begin
            if (force_close || change_close) begin
              tim_w_d[p_q]   = force_close ? {DEPTH{1'b1}} : u[DEPTH-1:0];
              lev_w_d[p_lev] = q;
              cur_d          = q;
              s_d            = SW'(1);
              if (p_q == '0) begin
                state_d = StCommit;
              end else begin
                p_d = p_q - 1'b1;
              end
            end else begin
              // Same level, or a single-unit glitch too short to close a slot.
              s_d = s_q + 1'b1;
            end
          end
        end
        StCommit: begin
          levels_d = lev_w_q;
          times_d  = tim_w_q;
          done_d   = 1'b1;
          if (trig_rise) begin
            state_d = StArmed;
            lev_w_d = '0;
            tim_w_d = '0;
            cur_d   = '0;
            s_d     = '0;
            p_d     = '0;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      levels_q <= '0;
      times_q  <= '0;
      lev_w_q  <= '0;
      tim_w_q  <= '0;
      cur_q    <= '0;
      s_q      <= '0;
      p_q      <= '0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      levels_q <= levels_d;
      times_q  <= times_d;
      lev_w_q  <= lev_w_d;
      tim_w_q  <= tim_w_d;
      cur_q    <= cur_d;
      s_q      <= s_d;
      p_q      <= p_d;
      trig_q   <= trig_d;
      done_q   <= done_d;
    end
  end

  assign levels = levels_q;
  assign times  = times_q;
  assign busy   = (state_q == StArmed) || (state_q == StRec);
  assign done   = done_q;

endmodule

// File: doc/env_recorder.md
Name: env_recorder

Overview:
- Capture-side counterpart of the envelope sequencer. Watches a fixed-point amplitude stream after a trigger and quantises it into DEPTH-bit levels. Measures how long each level is held, in TSCALE-sample units.
- Emits packed levels/times buses in exactly the slot layout the sequencer consumes, so a recorded gesture can be replayed directly.
- Sits between an amplitude source (filter/rectifier output) and an envelope sequencer instance.

Parameters:
- DEPTH, 4, bit width of each level and each time slot
- LEN, 4, number of level slots (LEN-1 time slots); LEN >= 2
- TSCALE, 1, samples per time unit; must be a power of two

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ena  in  1  clock enable; low freezes all state
- trigger  in  1  start or restart recording, rising-edge detected internally
- sampleValid  in  1  one-cycle strobe per audio sample
- sampleIn  in  `BITS  signed fixed-point amplitude (`FPWIDTH format)
- levels  out  DEPTH*LEN  committed levels; slot LEN-1 is the first level
- times  out  DEPTH*(LEN-1)  committed times; slot LEN-2 is the first duration
- busy  out  1  high while armed or recording
- done  out  1  one-cycle pulse when a recording is committed

Behaviour:
- Reset (rst low, asynchronous): levels=0, times=0, busy=0, done=0, state IDLE, all working registers 0.
- ena low: no state change, trigger edge detector holds its previous value, done forced 0.
- Quantiser: q = sampleIn >> (`FPWIDTH-DEPTH-1).
  - sampleIn MSB set (negative) -> q=0.
  - Result > 2^DEPTH-1 -> q = all ones.
- States:
  - IDLE: a trigger rising edge goes to ARMED.
  - ARMED: the first sampleValid writes q to working level slot LEN-1, sets cur=q, s=1, slot pointer p=LEN-2, then goes to REC.
  - REC: on each sampleValid, with u = s/TSCALE (a shift):
    - Force close: s == (2^DEPTH-1)*TSCALE -> times[p] = 2^DEPTH-1, levels[p] = q.
    - Change close: q != cur and u >= 1 -> times[p] = u, levels[p] = q.
    - Glitch: q != cur and u == 0 -> ignored, s++.
    - Otherwise s++.
    - After any close: cur=q, s=1, and p decrements if p != 0. If the closed slot was p == 0, go to COMMIT.
  - COMMIT: copy the working buses to levels/times, pulse done for one cycle, go to IDLE.
- Latency: done and the new levels/times appear 2 clocks after the clock that samples the final sampleValid (1 clock to register the close, 1 for COMMIT).
- busy is high in ARMED and REC, low in IDLE and COMMIT.
- levels/times change only in COMMIT, so a sequencer can keep replaying the old envelope while a new one is recorded.
- Trigger rising edge in ARMED or REC: abort, clear the working buses, go to ARMED. Committed outputs are kept.
- Trigger edge in the same cycle as the final close: trigger wins; no commit, no done.
- Trigger edge in COMMIT: the commit completes, then the block goes to ARMED instead of IDLE.
- Reset mid-operation clears committed outputs as well.
- Widths: s is DEPTH+log2(TSCALE) bits and never wraps, because force close bounds it.

Decomposition:
- Shared package env_pkg holds:
  - the state encoding (IDLE, ARMED, REC, COMMIT);
  - the quantiser shift constant derived from `FPWIDTH;
  - the slot-index helpers shared with the sequencer.
- One sub-module, env_quantize: a combinational saturating quantiser from sampleIn to DEPTH bits. It is reusable by other envelope blocks.

Test Plan (`FPWIDTH=16, DEPTH=4, LEN=4; q = sample>>11):
- TSCALE=1. Trigger, then samples: 3 x 16'h1800, 2 x 16'h4000, 4 x 16'h7800, 1 x 16'h0000 -> done pulses once 2 clks after the last sample; levels=16'h38F0, times=12'h324; busy falls before done.
- Saturation, TSCALE=1. Trigger, 20 x 16'h1800, 1 x 16'h4000, 1 x 16'h0000 -> levels=16'h3380, times=12'hF51.
- Glitch, TSCALE=2. Trigger, 4 x 16'h1800, 1 x 16'h4000, 1 x 16'h1800, 3 x 16'h4000, 2 x 16'h7800, 1 x 16'h0000:
  - the lone 16'h1800 is ignored;
  - result levels=16'h38F0, times=12'h221.
- Retrigger mid-REC after 5 samples -> outputs keep the previous committed values, busy stays 1, no done. The next full run commits only the new data.
- Async reset asserted mid-REC between clock edges -> levels, times, busy and done are 0 immediately. The first trigger after release behaves like a fresh start.
- ena held low for 10 cycles during REC while sampleValid pulses -> those samples are ignored. Result is identical to the same stream with those samples removed.
